// File: rtl/xnor_match_pkg.sv
// Shared defaults for the masked XNOR pattern matcher.
package xnor_match_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_HIT_RUN = 3;

endpackage

// File: rtl/xnor_match_unit_xnor_vec.sv
// Combinational masked bitwise XNOR: a bit counts as equal when it matches or is don't-care.
module xnor_vec
    import xnor_match_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] care,
    output logic [WIDTH-1:0] eq,
    output logic             all_eq
);

    assign eq     = ~(a ^ b) | ~care;
    assign all_eq = &eq;

endmodule

// File: rtl/xnor_match_unit.sv
// Registered pattern matcher: compares each valid word against a programmable masked
// pattern, tracks the consecutive-match run and total hits, and flags long runs.
module xnor_match_unit
    import xnor_match_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int HIT_RUN = DEF_HIT_RUN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_pat,
    input  logic [WIDTH-1:0] pat_in,
    input  logic [WIDTH-1:0] mask_in,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] bit_eq,
    output logic             match,
    output logic [CNT_W-1:0] run_cnt,
    output logic             detect,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] HIT_THR = CNT_W'(HIT_RUN);

    logic [WIDTH-1:0] pattern;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] eq_comb;
    logic             all_eq_comb;
    logic [CNT_W-1:0] run_next;
    logic [CNT_W-1:0] hit_next;

    xnor_vec #(
        .WIDTH(WIDTH)
    ) u_xnor_vec (
        .a      (in_data),
        .b      (pattern),
        .care   (mask),
        .eq     (eq_comb),
        .all_eq (all_eq_comb)
    );

    // Idle cycles leave both counters untouched so a gap never breaks a run.
    always_comb begin
        run_next = run_cnt;
        hit_next = hit_cnt;
        if (in_valid) begin
            if (all_eq_comb) begin
                run_next = (run_cnt == CNT_MAX) ? run_cnt : run_cnt + CNT_ONE;
                hit_next = (hit_cnt == CNT_MAX) ? hit_cnt : hit_cnt + CNT_ONE;
            end else begin
                run_next = '0;
            end
        end
    end

    // A load in the same cycle as a valid word still reports that word's compare
    // result (against the old pattern), but the load's counter clear takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern   <= '0;
            mask      <= '1;
            out_valid <= 1'b0;
            bit_eq    <= '0;
            match     <= 1'b0;
            run_cnt   <= '0;
            hit_cnt   <= '0;
            detect    <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                bit_eq <= eq_comb;
                match  <= all_eq_comb;
            end
            if (load_pat) begin
                pattern <= pat_in;
                mask    <= mask_in;
                run_cnt <= '0;
                hit_cnt <= '0;
                detect  <= 1'b0;
            end else begin
                run_cnt <= run_next;
                hit_cnt <= hit_next;
                detect  <= (run_next >= HIT_THR);
            end
        end
    end

endmodule

// File: tb/tb_xnor_match_unit.sv
// Scoreboard bench for xnor_match_unit (WIDTH=8, CNT_W=4, HIT_RUN=3).
module tb_xnor_match_unit;

    localparam int WIDTH   = 8;
    localparam int CNT_W   = 4;
    localparam int HIT_RUN = 3;

    typedef struct packed {
        logic             ov;
        logic [WIDTH-1:0] be;
        logic             m;
        logic [CNT_W-1:0] run;
        logic             det;
        logic [CNT_W-1:0] hit;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             load_pat;
    logic [WIDTH-1:0] pat_in;
    logic [WIDTH-1:0] mask_in;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic [WIDTH-1:0] bit_eq;
    logic             match;
    logic [CNT_W-1:0] run_cnt;
    logic             detect;
    logic [CNT_W-1:0] hit_cnt;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];
    exp_t e;

    // Reference model state
    logic [WIDTH-1:0] m_pat  = '0;
    logic [WIDTH-1:0] m_mask = '1;
    logic [WIDTH-1:0] m_be   = '0;
    logic             m_match = 1'b0;
    int               m_run  = 0;
    int               m_hit  = 0;
    logic             m_det  = 1'b0;

    xnor_match_unit #(
        .WIDTH   (WIDTH),
        .CNT_W   (CNT_W),
        .HIT_RUN (HIT_RUN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_pat  (load_pat),
        .pat_in    (pat_in),
        .mask_in   (mask_in),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .bit_eq    (bit_eq),
        .match     (match),
        .run_cnt   (run_cnt),
        .detect    (detect),
        .hit_cnt   (hit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle, pushes the model's expectation, and returns #1 after the edge.
    task automatic step(input logic r, input logic ld, input logic [WIDTH-1:0] p,
                        input logic [WIDTH-1:0] mk, input logic v, input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] be;
        logic             mt;
        exp_t             x;
        @(negedge clk);
        rst = r; load_pat = ld; pat_in = p; mask_in = mk; in_valid = v; in_data = d;
        be = ~(d ^ m_pat) | ~m_mask;
        mt = &be;
        if (r) begin
            m_pat = '0; m_mask = '1; m_be = '0; m_match = 1'b0;
            m_run = 0; m_hit = 0; m_det = 1'b0;
            x.ov = 1'b0;
        end else begin
            x.ov = v;
            if (v) begin
                m_be = be;
                m_match = mt;
            end
            if (ld) begin
                m_pat = p; m_mask = mk;
                m_run = 0; m_hit = 0; m_det = 1'b0;
            end else begin
                if (v) begin
                    if (mt) begin
                        if (m_run < 15) m_run++;
                        if (m_hit < 15) m_hit++;
                    end else begin
                        m_run = 0;
                    end
                end
                m_det = (m_run >= HIT_RUN);
            end
        end
        x.be = m_be; x.m = m_match; x.run = CNT_W'(m_run); x.det = m_det; x.hit = CNT_W'(m_hit);
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'hFF);
        e = sb.pop_front();
        checks++;
        if ({out_valid, bit_eq, match, run_cnt, detect, hit_cnt} !== e) begin
            errors++;
            $display("[TB] FAIL reset_sb: got ov=%b be=%h m=%b run=%0d det=%b hit=%0d, expected ov=%b be=%h m=%b run=%0d det=%b hit=%0d",
                     out_valid, bit_eq, match, run_cnt, detect, hit_cnt, e.ov, e.be, e.m, e.run, e.det, e.hit);
        end
        checks++;
        if ({out_valid, bit_eq, match, run_cnt, detect, hit_cnt} !== 19'd0) begin
            errors++;
            $display("[TB] FAIL reset_zero: got %h, expected 0",
                     {out_valid, bit_eq, match, run_cnt, detect, hit_cnt});
        end
    endtask

    task automatic test_match();
        step(1'b0, 1'b1, 8'hA5, 8'hFF, 1'b0, 8'h00);
        e = sb.pop_front();
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hA5);
            e = sb.pop_front();
            checks++;
            if ({out_valid, bit_eq, match, run_cnt, detect, hit_cnt} !== e) begin
                errors++;
                $display("[TB] FAIL match_sb%0d: got ov=%b be=%h m=%b run=%0d det=%b hit=%0d, expected ov=%b be=%h m=%b run=%0d det=%b hit=%0d",
                         i, out_valid, bit_eq, match, run_cnt, detect, hit_cnt, e.ov, e.be, e.m, e.run, e.det, e.hit);
            end
            checks++;
            if (match !== 1'b1 || run_cnt !== CNT_W'(i) || detect !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL match_run%0d: got m=%b run=%0d det=%b, expected m=1 run=%0d det=%b",
                         i, match, run_cnt, detect, i, (i == 3));
            end
        end
        checks++;
        if (hit_cnt !== 4'd3) begin
            errors++;
            $display("[TB] FAIL match_hit: got %0d, expected 3", hit_cnt);
        end
    endtask

    task automatic test_mismatch();
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hA4);
        e = sb.pop_front();
        checks++;
        if ({out_valid, bit_eq, match, run_cnt, detect, hit_cnt} !== e) begin
            errors++;
            $display("[TB] FAIL mismatch_sb: got ov=%b be=%h m=%b run=%0d det=%b hit=%0d, expected ov=%b be=%h m=%b run=%0d det=%b hit=%0d",
                     out_valid, bit_eq, match, run_cnt, detect, hit_cnt, e.ov, e.be, e.m, e.run, e.det, e.hit);
        end
        checks++;
        if (bit_eq !== 8'hFE || match !== 1'b0 || run_cnt !== 4'd0 || detect !== 1'b0 || hit_cnt !== 4'd3) begin
            errors++;
            $display("[TB] FAIL mismatch_fixed: got be=%h m=%b run=%0d det=%b hit=%0d, expected be=fe m=0 run=0 det=0 hit=3",
                     bit_eq, match, run_cnt, detect, hit_cnt);
        end
    endtask

    task automatic test_mask_gaps();
        step(1'b0, 1'b1, 8'hA5, 8'hF0, 1'b0, 8'h00);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 8'h00, 8'h00, (i % 2 == 0), 8'hA0);
            e = sb.pop_front();
            checks++;
            if ({out_valid, bit_eq, match, run_cnt, detect, hit_cnt} !== e) begin
                errors++;
                $display("[TB] FAIL gaps_sb%0d: got ov=%b be=%h m=%b run=%0d det=%b hit=%0d, expected ov=%b be=%h m=%b run=%0d det=%b hit=%0d",
                         i, out_valid, bit_eq, match, run_cnt, detect, hit_cnt, e.ov, e.be, e.m, e.run, e.det, e.hit);
            end
        end
        checks++;
        if (bit_eq !== 8'hFF || match !== 1'b1 || run_cnt !== 4'd3 || detect !== 1'b1) begin
            errors++;
            $display("[TB] FAIL gaps_fixed: got be=%h m=%b run=%0d det=%b, expected be=ff m=1 run=3 det=1",
                     bit_eq, match, run_cnt, detect);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hA0);
            e = sb.pop_front();
            checks++;
            if ({out_valid, bit_eq, match, run_cnt, detect, hit_cnt} !== e) begin
                errors++;
                $display("[TB] FAIL sat_sb%0d: got run=%0d det=%b hit=%0d, expected run=%0d det=%b hit=%0d",
                         i, run_cnt, detect, hit_cnt, e.run, e.det, e.hit);
            end
        end
        checks++;
        if (run_cnt !== 4'd15 || hit_cnt !== 4'd15 || detect !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sat_fixed: got run=%0d hit=%0d det=%b, expected run=15 hit=15 det=1",
                     run_cnt, hit_cnt, detect);
        end
    endtask

    task automatic test_load_collision();
        step(1'b0, 1'b1, 8'h3C, 8'hFF, 1'b1, 8'hA5);
        e = sb.pop_front();
        checks++;
        if ({out_valid, bit_eq, match, run_cnt, detect, hit_cnt} !== e) begin
            errors++;
            $display("[TB] FAIL collide_sb: got ov=%b be=%h m=%b run=%0d det=%b hit=%0d, expected ov=%b be=%h m=%b run=%0d det=%b hit=%0d",
                     out_valid, bit_eq, match, run_cnt, detect, hit_cnt, e.ov, e.be, e.m, e.run, e.det, e.hit);
        end
        checks++;
        if (out_valid !== 1'b1 || match !== 1'b1 || run_cnt !== 4'd0 || hit_cnt !== 4'd0 || detect !== 1'b0) begin
            errors++;
            $display("[TB] FAIL collide_fixed: got ov=%b m=%b run=%0d hit=%0d det=%b, expected ov=1 m=1 run=0 hit=0 det=0",
                     out_valid, match, run_cnt, hit_cnt, detect);
        end
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h3C);
        e = sb.pop_front();
        checks++;
        if (match !== 1'b1 || run_cnt !== 4'd1) begin
            errors++;
            $display("[TB] FAIL collide_newpat: got m=%b run=%0d, expected m=1 run=1", match, run_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] d;
        logic             v;
        step(1'b0, 1'b1, 8'h3C, 8'hCF, 1'b0, 8'h00);
        e = sb.pop_front();
        for (int i = 0; i < 40; i++) begin
            if (i == 25) begin
                step(1'b0, 1'b1, 8'h77, 8'h00, 1'b1, 8'h3C);
            end else begin
                v = ($urandom_range(0, 3) != 0);
                d = ($urandom_range(0, 2) != 0) ? (8'h3C ^ 8'(($urandom_range(0, 1) != 0) ? 8'h30 : 8'h00))
                                                : 8'($urandom);
                step(1'b0, 1'b0, 8'h00, 8'h00, v, d);
            end
            e = sb.pop_front();
            checks++;
            if ({out_valid, bit_eq, match, run_cnt, detect, hit_cnt} !== e) begin
                errors++;
                $display("[TB] FAIL b2b_sb%0d: got ov=%b be=%h m=%b run=%0d det=%b hit=%0d, expected ov=%b be=%h m=%b run=%0d det=%b hit=%0d",
                         i, out_valid, bit_eq, match, run_cnt, detect, hit_cnt, e.ov, e.be, e.m, e.run, e.det, e.hit);
            end
            if (i > 25 && out_valid === 1'b1) begin
                checks++;
                if (match !== 1'b1 || bit_eq !== 8'hFF) begin
                    errors++;
                    $display("[TB] FAIL dontcare%0d: got m=%b be=%h, expected m=1 be=ff", i, match, bit_eq);
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        step(1'b0, 1'b1, 8'h11, 8'hFF, 1'b0, 8'h00);
        e = sb.pop_front();
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h11);
        e = sb.pop_front();
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h11);
        e = sb.pop_front();
        checks++;
        if (run_cnt !== 4'd2) begin
            errors++;
            $display("[TB] FAIL midrun_pre: got run=%0d, expected 2", run_cnt);
        end
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h11);
        e = sb.pop_front();
        checks++;
        if ({out_valid, bit_eq, match, run_cnt, detect, hit_cnt} !== 19'd0) begin
            errors++;
            $display("[TB] FAIL midrun_rst: got %h, expected 0",
                     {out_valid, bit_eq, match, run_cnt, detect, hit_cnt});
        end
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00);
        e = sb.pop_front();
        checks++;
        if (match !== 1'b1 || bit_eq !== 8'hFF || run_cnt !== 4'd1 || hit_cnt !== 4'd1) begin
            errors++;
            $display("[TB] FAIL midrun_zero: got m=%b be=%h run=%0d hit=%0d, expected m=1 be=ff run=1 hit=1",
                     match, bit_eq, run_cnt, hit_cnt);
        end
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h01);
        e = sb.pop_front();
        checks++;
        if (match !== 1'b0 || bit_eq !== 8'hFE || run_cnt !== 4'd0) begin
            errors++;
            $display("[TB] FAIL midrun_mask: got m=%b be=%h run=%0d, expected m=0 be=fe run=0",
                     match, bit_eq, run_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; load_pat = 1'b0; pat_in = '0; mask_in = '0; in_valid = 1'b0; in_data = '0;
        $display("[TB] start");
        test_reset();
        test_match();
        test_mismatch();
        test_mask_gaps();
        test_saturation();
        test_load_collision();
        test_back_to_back();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
